// File: rtl/ifid_fetch_queue_if.sv
// Fetch/decode handshake bundle for ifid_fetch_queue.
// The slave modport is the queue; the master modport is the fetch/decode environment.
interface ifid_fetch_queue_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/ifid_fetch_queue.sv
// IF/ID fetch queue: DEPTH-entry FIFO of (PC, instruction) pairs with flush.
// Optional decode back-pressure counter enabled by macro IFID_STALL_CNT_EN.
module ifid_fetch_queue #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    ifid_fetch_queue_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                stall_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               in_ready_s;
    logic               out_valid_s;
    logic               enq_s;
    logic               deq_s;
    entry_t             head_s;

    // Handshake qualifiers; flush vetoes both transfers.
    always_comb begin
        in_ready_s  = (count_r != CNT_W'(DEPTH));
        out_valid_s = (count_r != {CNT_W{1'b0}});
        enq_s       = bus.in_valid && in_ready_s && !flush;
        deq_s       = out_valid_s && bus.out_ready && !flush;
    end

    // Head read-out, masked to zero while the queue is empty.
    always_comb begin
        head_s        = mem_r[rd_ptr_r];
        bus.in_ready  = in_ready_s;
        bus.out_valid = out_valid_s;
        if (out_valid_s) begin
            bus.out_pc    = head_s.pc;
            bus.out_instr = head_s.instr;
        end else begin
            bus.out_pc    = {PC_W{1'b0}};
            bus.out_instr = {INSTR_W{1'b0}};
        end
    end

    // Pointer and occupancy state; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (enq_s && !deq_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (deq_s && !enq_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

    // Entry storage; stale contents are harmless because count gates the head.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_r[wr_ptr_r] <= '{pc: bus.in_pc, instr: bus.in_instr};
        end
    end

    assign count = count_r;

`ifdef IFID_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where decode refuses a valid head.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (out_valid_s && !bus.out_ready && !flush &&
                     (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 32'h0000_0000;
`endif

endmodule
